// File: rtl/button_debounce_repeat.sv
// button_debounce_repeat
// Conditions one raw push-button for the counter stage: two-flop synchroniser,
// consecutive-sample debounce, then an FSM that emits one increment pulse per
// press and, when enabled, repeat pulses at a fixed rate after a long hold.
module button_debounce_repeat #(
  parameter int DB_CYCLES     = 16,
  parameter int DB_W          = 5,
  parameter int HOLD_CYCLES   = 64,
  parameter int REPEAT_CYCLES = 16,
  parameter int TMR_W         = 8
) (
  input  logic clk,
  input  logic nrst,
  input  logic btn_in,
  input  logic enable_repeat,
  output logic pressed,
  output logic pulse,
  output logic held
);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEAT    = 2'd2
  } state_t;

  logic              s1;
  logic              btn_s;
  logic [DB_W-1:0]   db_cnt;
  state_t            state;
  logic [TMR_W-1:0]  tmr;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      s1    <= btn_in;
      btn_s <= s1;
    end
  end

  // Debounce: flip the level only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      db_cnt  <= '0;
      pressed <= 1'b0;
    end else if (btn_s == pressed) begin
      db_cnt  <= '0;
    end else if (db_cnt == DB_LAST) begin
      pressed <= ~pressed;
      db_cnt  <= '0;
    end else begin
      db_cnt  <= db_cnt + DB_W'(1);
    end
  end

  // Press / hold / repeat FSM with registered pulse and held outputs.
  // IDLE is only ever entered with pressed low (release or reset), so seeing
  // pressed high while in IDLE is exactly the debounced rising edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      tmr   <= '0;
      pulse <= 1'b0;
      held  <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          tmr  <= '0;
          held <= 1'b0;
          if (pressed) begin
            pulse <= 1'b1;
            state <= WAIT_HOLD;
          end
        end
        WAIT_HOLD: begin
          if (!pressed) begin
            state <= IDLE;
            tmr   <= '0;
          end else if (!enable_repeat) begin
            tmr   <= '0;
          end else if (tmr == HOLD_LAST) begin
            pulse <= 1'b1;
            tmr   <= '0;
            held  <= 1'b1;
            state <= REPEAT;
          end else begin
            tmr   <= tmr + TMR_W'(1);
          end
        end
        REPEAT: begin
          // Release is checked first so a coincident timer expiry emits nothing.
          if (!pressed) begin
            state <= IDLE;
            tmr   <= '0;
            held  <= 1'b0;
          end else if (!enable_repeat) begin
            state <= WAIT_HOLD;
            tmr   <= '0;
            held  <= 1'b0;
          end else if (tmr == REP_LAST) begin
            pulse <= 1'b1;
            tmr   <= '0;
          end else begin
            tmr   <= tmr + TMR_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tmr   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule
